// File: rtl/clk_div_gen.sv
// Programmable clock divider: integer ratio N with an even/odd phase split, glitch-free
// ratio changes at period boundaries, graceful stop, and a combinational N=1 bypass.
module clk_div_gen #(
    parameter int DIV_W         = 8,
    parameter bit ODD_HIGH_LONG = 1'b0
) (
    input  logic             i_ref_clk,
    input  logic             i_rst,
    input  logic             i_clk_en,
    input  logic [DIV_W-1:0] i_div_ratio,
    output logic             o_div_clk,
    output logic             o_tick,
    output logic             o_busy,
    output logic [DIV_W-1:0] o_active_ratio
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, BYPASS} state_t;

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] half;
    logic [DIV_W-1:0] h_last;
    logic [DIV_W-1:0] l_last;
    logic             div_q;
    logic             tick_q;
    logic             start_ok;
    logic             byp_ok;
    logic             boundary;

    // Terminal counts are H-1 and L-1; both fit in DIV_W bits for any N >= 2.
    always_comb begin
        half   = o_active_ratio >> 1;
        h_last = half - ONE;
        l_last = half - ONE;
        if (o_active_ratio[0]) begin
            if (ODD_HIGH_LONG) h_last = half;
            else               l_last = half;
        end
    end

    assign start_ok = i_clk_en && (i_div_ratio > ONE);
    assign byp_ok   = i_clk_en && (i_div_ratio == ONE);
    assign boundary = (state == IDLE) || ((state == LOW) && (cnt == l_last));

    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            cnt            <= '0;
            div_q          <= 1'b0;
            tick_q         <= 1'b0;
            o_active_ratio <= '0;
        end else begin
            tick_q <= 1'b0;
            // The only place a new ratio or enable is acted upon.
            if (boundary) begin
                cnt <= '0;
                if (start_ok) begin
                    state          <= HIGH;
                    div_q          <= 1'b1;
                    tick_q         <= 1'b1;
                    o_active_ratio <= i_div_ratio;
                end else if (byp_ok) begin
                    state          <= BYPASS;
                    div_q          <= 1'b0;
                    o_active_ratio <= ONE;
                end else begin
                    state <= IDLE;
                    div_q <= 1'b0;
                end
            end else begin
                case (state)
                    HIGH: begin
                        if (cnt == h_last) begin
                            state <= LOW;
                            cnt   <= '0;
                            div_q <= 1'b0;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    LOW:     cnt <= cnt + ONE;
                    BYPASS:  if (!byp_ok) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign o_div_clk = (state == BYPASS) ? (i_ref_clk & ~i_rst) : div_q;
    assign o_tick    = tick_q;
    assign o_busy    = (state != IDLE);

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: fixed vector table, directed corner sequences and a random run,
// with both odd-split variants checked every cycle against a waveform-level model.
module tb_clk_div_gen;

    logic       ref_clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] ratio = 8'd0;
    logic       d0_div, d0_tick, d0_busy, d1_div, d1_tick, d1_busy;
    logic [7:0] d0_ratio, d1_ratio;

    int total = 0;
    int bad   = 0;

    always #5 ref_clk = ~ref_clk;

    clk_div_gen #(.DIV_W(8), .ODD_HIGH_LONG(1'b0)) dut0 (
        .i_ref_clk(ref_clk), .i_rst(rst), .i_clk_en(en), .i_div_ratio(ratio),
        .o_div_clk(d0_div), .o_tick(d0_tick), .o_busy(d0_busy), .o_active_ratio(d0_ratio));

    clk_div_gen #(.DIV_W(8), .ODD_HIGH_LONG(1'b1)) dut1 (
        .i_ref_clk(ref_clk), .i_rst(rst), .i_clk_en(en), .i_div_ratio(ratio),
        .o_div_clk(d1_div), .o_tick(d1_tick), .o_busy(d1_busy), .o_active_ratio(d1_ratio));

    // Model: one period is a precomputed waveform (H ones then L zeros) played out sample
    // by sample; decisions happen only when no period is being played. Index k = ODD_HIGH_LONG.
    int m_mode[2];   // 0 idle, 1 running, 2 bypass
    int m_ratio[2];
    int m_plen[2];
    int m_ppos[2];
    bit m_cd[2];
    bit m_ct[2];
    bit m_pat[2][512];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input int k, input bit r, input bit e, input int n);
        int h;
        if (r) begin
            m_mode[k] = 0; m_ratio[k] = 0; m_plen[k] = 0; m_ppos[k] = 0;
            m_cd[k] = 0; m_ct[k] = 0;
        end else if (m_mode[k] == 1 && m_ppos[k] < m_plen[k]) begin
            m_cd[k] = m_pat[k][m_ppos[k]];
            m_ct[k] = (m_ppos[k] == 0);
            m_ppos[k]++;
        end else if (m_mode[k] == 2 && e && n == 1) begin
            m_ct[k] = 0;
        end else if (m_mode[k] == 2) begin
            m_mode[k] = 0; m_cd[k] = 0; m_ct[k] = 0;
        end else if (e && n >= 2) begin
            if (n % 2 == 0) h = n / 2;
            else            h = (k == 1) ? (n + 1) / 2 : (n - 1) / 2;
            for (int i = 0; i < n; i++) m_pat[k][i] = (i < h);
            m_ratio[k] = n; m_plen[k] = n; m_mode[k] = 1;
            m_cd[k] = 1; m_ct[k] = 1; m_ppos[k] = 1;
        end else if (e && n == 1) begin
            m_mode[k] = 2; m_ratio[k] = 1; m_cd[k] = 0; m_ct[k] = 0;
        end else begin
            m_mode[k] = 0; m_cd[k] = 0; m_ct[k] = 0;
        end
    endtask

    function automatic int exp_div(input int k);
        return (m_mode[k] == 2) ? int'(ref_clk & ~rst) : int'(m_cd[k]);
    endfunction

    task automatic check_model();
        chk("m0_div",   d0_div,   exp_div(0));
        chk("m0_tick",  d0_tick,  m_ct[0]);
        chk("m0_busy",  d0_busy,  m_mode[0] != 0);
        chk("m0_ratio", d0_ratio, m_ratio[0]);
        chk("m1_div",   d1_div,   exp_div(1));
        chk("m1_tick",  d1_tick,  m_ct[1]);
        chk("m1_busy",  d1_busy,  m_mode[1] != 0);
        chk("m1_ratio", d1_ratio, m_ratio[1]);
    endtask

    // One reference cycle: low-phase check, drive inputs, rising edge, model step, high-phase check.
    task automatic step(input bit r, input bit e, input int n);
        @(negedge ref_clk);
        #1;
        chk("m0_div_low", d0_div, exp_div(0));
        chk("m1_div_low", d1_div, exp_div(1));
        rst = r; en = e; ratio = 8'(n);
        @(posedge ref_clk);
        model_edge(0, r, e, n);
        model_edge(1, r, e, n);
        #1;
        check_model();
    endtask

    typedef struct {
        bit r; bit e; int n;
        bit div; bit tick; bit busy; int ratio;
    } vec_t;

    vec_t tbl[22];
    logic [31:0] cap;
    logic [31:0] cap1;
    bit   cur_e;
    int   cur_n;

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_ratio[k] = 0; m_plen[k] = 0; m_ppos[k] = 0;
            m_cd[k] = 0; m_ct[k] = 0;
        end

        // N=4 run, switch to N=5 (2/3 split), graceful stop, N=0 stays idle, N=1 bypass.
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 4, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 4, 1, 1, 1, 4};
        tbl[3]  = '{0, 1, 4, 1, 0, 1, 4};
        tbl[4]  = '{0, 1, 4, 0, 0, 1, 4};
        tbl[5]  = '{0, 1, 4, 0, 0, 1, 4};
        tbl[6]  = '{0, 1, 4, 1, 1, 1, 4};
        tbl[7]  = '{0, 1, 4, 1, 0, 1, 4};
        tbl[8]  = '{0, 1, 4, 0, 0, 1, 4};
        tbl[9]  = '{0, 1, 5, 0, 0, 1, 4};
        tbl[10] = '{0, 1, 5, 1, 1, 1, 5};
        tbl[11] = '{0, 1, 5, 1, 0, 1, 5};
        tbl[12] = '{0, 1, 5, 0, 0, 1, 5};
        tbl[13] = '{0, 1, 5, 0, 0, 1, 5};
        tbl[14] = '{0, 1, 5, 0, 0, 1, 5};
        tbl[15] = '{0, 0, 5, 0, 0, 0, 5};
        tbl[16] = '{0, 0, 0, 0, 0, 0, 5};
        tbl[17] = '{0, 1, 0, 0, 0, 0, 5};
        tbl[18] = '{0, 1, 1, 1, 0, 1, 1};
        tbl[19] = '{0, 1, 1, 1, 0, 1, 1};
        tbl[20] = '{0, 0, 1, 0, 0, 0, 1};
        tbl[21] = '{1, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 22; i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].n);
            chk($sformatf("tbl%0d_div", i),   d0_div,   tbl[i].div);
            chk($sformatf("tbl%0d_tick", i),  d0_tick,  tbl[i].tick);
            chk($sformatf("tbl%0d_busy", i),  d0_busy,  tbl[i].busy);
            chk($sformatf("tbl%0d_ratio", i), d0_ratio, tbl[i].ratio);
        end

        // N=5 on both odd-split variants: 2/3 and 3/2.
        step(1, 0, 0);
        cap = '0; cap1 = '0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 5);
            cap = {cap[30:0], d0_div}; cap1 = {cap1[30:0], d1_div};
        end
        chk("n5_low_long",  cap[9:0],  10'b1100011000);
        chk("n5_high_long", cap1[9:0], 10'b1110011100);

        // N=6 running, ratio changed to 3 during HIGH of the second period.
        step(1, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 6);
        cap = '0;
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 3);
            cap = {cap[30:0], d0_div};
            if (i == 4) chk("chg_ratio_old", d0_ratio, 6);
            if (i == 5) chk("chg_ratio_new", d0_ratio, 3);
        end
        chk("chg_wave", cap[8:0], 9'b110001001);

        // N=8, enable dropped on the 2nd high cycle: full 4/4 period then idle.
        step(1, 0, 0);
        step(0, 1, 8);
        step(0, 1, 8);
        cap = '0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 8);
            cap = {cap[30:0], d0_div};
            if (i == 5) chk("stop_busy_mid", d0_busy, 1);
        end
        chk("stop_wave", cap[7:0], 8'b11000000);
        chk("stop_busy", d0_busy, 0);
        chk("stop_div",  d0_div,  0);

        // Reset mid-HIGH with N=10, then 1-cycle restart.
        step(1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 10);
        step(1, 1, 10);
        chk("rst_hi_div",  d0_div, 0);
        chk("rst_hi_busy", d0_busy, 0);
        chk("rst_hi_ratio", d0_ratio, 0);
        step(0, 1, 10);
        chk("rst_hi_restart", d0_div, 1);

        // Reset in BYPASS: output gated low immediately while the reference is high.
        step(1, 0, 0);
        step(0, 1, 1);
        step(0, 1, 1);
        chk("byp_track_hi", d0_div, 1);
        #2 rst = 1'b1;
        #1 chk("byp_rst_comb", d0_div, 0);
        step(1, 1, 1);
        chk("byp_rst_busy",  d0_busy, 0);
        chk("byp_rst_ratio", d0_ratio, 0);
        step(0, 1, 10);
        chk("byp_restart", d0_div, 1);

        // Random traffic against the model.
        cur_e = 1'b1; cur_n = 4;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0)
                cur_n = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 12));
            if ($urandom_range(0, 29) == 0) cur_e = ~cur_e;
            step($urandom_range(0, 149) == 0, cur_e, cur_n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 The block SHALL have parameter DIV_W, default 8: width of the ratio input and of the internal counters.
REQ-002 The block SHALL have parameter ODD_HIGH_LONG, default 0: for odd ratios, 1 = high phase is the longer phase, 0 = low phase is the longer phase.
REQ-003 The block SHALL have port i_ref_clk, input, 1 bit: the single reference clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port i_clk_en, input, 1 bit: divider enable.
REQ-006 The block SHALL have port i_div_ratio, input, DIV_W bits: requested division ratio N.
REQ-007 The block SHALL have port o_div_clk, output, 1 bit: divided clock.
REQ-008 The block SHALL have port o_tick, output, 1 bit: one-cycle registered pulse marking each o_div_clk rising edge.
REQ-009 The block SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 The block SHALL have port o_active_ratio, output, DIV_W bits: the ratio currently in effect.

Function
REQ-011 The block SHALL implement a state machine with states IDLE, HIGH, LOW and BYPASS.
REQ-012 Phase lengths SHALL be computed from the active ratio N, not from the live i_div_ratio.
- Even N: H = L = N/2.
- Odd N with ODD_HIGH_LONG=1: H = (N+1)/2 and L = (N-1)/2.
- Odd N with ODD_HIGH_LONG=0: H = (N-1)/2 and L = (N+1)/2.
REQ-013 In IDLE, the next edge SHALL act on the inputs as follows.
- i_clk_en=1 and N>=2: latch N into o_active_ratio, enter HIGH, set counter=0, set o_div_clk=1, pulse o_tick.
- i_clk_en=1 and N=1: enter BYPASS.
- Otherwise (including N=0): remain in IDLE with o_div_clk low.
REQ-014 In HIGH, the counter SHALL increment each cycle; at counter==H-1 the next edge enters LOW, clears the counter and drives o_div_clk low.
REQ-015 In LOW, at counter==L-1 the next edge SHALL act on the inputs as follows.
- i_clk_en=1 and N>=2: re-latch N, enter HIGH, pulse o_tick.
- i_clk_en=1 and N=1: enter BYPASS.
- Otherwise: enter IDLE.
REQ-016 A change of i_div_ratio SHALL take effect only at a period boundary (end of LOW) or when leaving IDLE; a period in progress always completes with its latched ratio, so there is no glitch and no truncated phase.
REQ-017 Deasserting i_clk_en during HIGH or LOW SHALL let the current period complete (graceful stop) before IDLE.
REQ-018 In BYPASS, o_div_clk SHALL equal i_ref_clk combinationally and o_active_ratio SHALL be 1; when i_clk_en=0 or i_div_ratio!=1, the next edge enters IDLE.
REQ-019 Apart from the bypass path, o_div_clk and o_tick SHALL be driven directly from flops (no combinational decode).
REQ-020 Counter comparisons SHALL be DIV_W bits wide with no overflow for N up to 2^DIV_W-1.
REQ-021 o_tick SHALL be 0 in IDLE and BYPASS.
REQ-022 The latency from i_clk_en sampled high in IDLE to o_div_clk high SHALL be 1 cycle.

Reset
REQ-023 While i_rst=1 at an edge, the block SHALL set state=IDLE, counter=0, o_div_clk=0, o_tick=0, o_busy=0 and o_active_ratio=0.
REQ-024 The bypass path SHALL be gated by !i_rst so that o_div_clk is low during any cycle with i_rst asserted.
REQ-025 Reset SHALL override enable and ratio in every state, including mid-period and BYPASS.

Verification
REQ-026 The bench SHALL cover: N=4, enable held -> o_div_clk repeats 2 high/2 low; o_tick once per 4 cycles; o_busy=1.
REQ-027 The bench SHALL cover: N=5, ODD_HIGH_LONG=0 -> 2 high/3 low; with ODD_HIGH_LONG=1 -> 3 high/2 low.
REQ-028 The bench SHALL cover: N=6 running, change to N=3 during the HIGH phase -> the current period finishes as 3/3, then 1/2 from the next period; o_active_ratio updates at the boundary.
REQ-029 The bench SHALL cover: N=8, drop i_clk_en at the 2nd high cycle -> 4 high, 4 low, then IDLE with o_busy=0 and o_div_clk=0.
REQ-030 The bench SHALL cover: N=1 with enable -> BYPASS after one edge, o_div_clk tracks i_ref_clk; N=0 with enable -> stays IDLE with output low.
REQ-031 The bench SHALL cover: i_rst pulsed mid-HIGH with N=10, and separately in BYPASS -> all outputs 0 at the next edge (bypass output low immediately); restart latency is 1 cycle after release.
